// File: rtl/fract_muldiv_seq_pkg.sv
// Shared types and widths for the sequential FMUL/FDIV mantissa core.
// Optional build macro: FMUL_RADIX4_EN (two multiplier bits per cycle).
package fpu_seq_pkg;

  localparam int FRAC_W = 24;
  localparam int QUO_W  = 50;
  localparam int PROD_W = 2 * FRAC_W;
  localparam int CNT_W  = $clog2(QUO_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fract_muldiv_seq_if.sv
// Start/done handshake and result bus between pre-normalization, the
// mantissa core and post-normalization.
interface fract_muldiv_seq_if;
  import fpu_seq_pkg::*;

  logic              start;
  logic              op_div;
  logic [FRAC_W-1:0] fracta;
  logic [FRAC_W-1:0] fractb;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] prod;
  logic [QUO_W-1:0]  quo;
  logic [FRAC_W-1:0] rem;
  logic              div_zero;

  modport master (
    output start, op_div, fracta, fractb,
    input  busy, done, prod, quo, rem, div_zero
  );

  modport slave (
    input  start, op_div, fracta, fractb,
    output busy, done, prod, quo, rem, div_zero
  );

endinterface

// File: rtl/fract_muldiv_seq_div_step.sv
// One combinational restoring-division step; kept separate so a square-root
// core can share the same compare/subtract.
module fract_div_step
  import fpu_seq_pkg::*;
(
  input  logic [FRAC_W:0]   r_in,
  input  logic [FRAC_W-1:0] divisor,
  input  logic              dvd_bit,
  output logic [FRAC_W:0]   r_out,
  output logic              q_bit
);

  logic [FRAC_W:0] r_shift;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    r_shift = {r_in[FRAC_W-1:0], dvd_bit};
    q_bit   = (r_shift >= {1'b0, divisor});
    r_out   = q_bit ? (r_shift - {1'b0, divisor}) : r_shift;
  end

endmodule

// File: rtl/fract_muldiv_seq.sv
// Sequential mantissa multiply (shift-add) / divide (restoring) core.
// Build macro FMUL_RADIX4_EN retires two multiplier bits per MUL cycle.
module fract_muldiv_seq
  import fpu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fract_muldiv_seq_if.slave    bus
);

`ifdef FMUL_RADIX4_EN
  localparam int MUL_STEP = 2;
  if ((FRAC_W % 2) != 0) begin : g_frac_w_odd
    $error("FMUL_RADIX4_EN requires an even FRAC_W");
  end
`else
  localparam int MUL_STEP = 1;
`endif

  state_t              state;
  logic [FRAC_W-1:0]   a_reg;
  logic [FRAC_W-1:0]   b_reg;
  logic [PROD_W-1:0]   acc;
  logic [QUO_W-1:0]    dvd;
  logic [FRAC_W:0]     r;
  logic [CNT_W-1:0]    cnt;

  logic                busy_q;
  logic                done_q;
  logic [PROD_W-1:0]   prod_q;
  logic [QUO_W-1:0]    quo_q;
  logic [FRAC_W-1:0]   rem_q;
  logic                div_zero_q;

  logic [PROD_W-1:0]   a_shift;
  logic [PROD_W-1:0]   acc_next;
  logic [FRAC_W:0]     r_next;
  logic                q_bit;
  logic [QUO_W-1:0]    dvd_next;
  logic                mul_last;
  logic                div_last;

  always_comb begin
    a_shift = PROD_W'(a_reg) << cnt;
`ifdef FMUL_RADIX4_EN
    acc_next = acc + (b_reg[0] ? a_shift : '0) + (b_reg[1] ? (a_shift << 1) : '0);
`else
    acc_next = acc + (b_reg[0] ? a_shift : '0);
`endif
  end

  fract_div_step u_div_step (
    .r_in    (r),
    .divisor (b_reg),
    .dvd_bit (dvd[QUO_W-1]),
    .r_out   (r_next),
    .q_bit   (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after QUO_W steps dvd holds the full quotient.
  assign dvd_next = {dvd[QUO_W-2:0], q_bit};
  assign mul_last = (cnt == CNT_W'(FRAC_W - MUL_STEP));
  assign div_last = (cnt == CNT_W'(QUO_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      dvd        <= '0;
      r          <= '0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      prod_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_reg  <= bus.fracta;
            b_reg  <= bus.fractb;
            acc    <= '0;
            dvd    <= {bus.fracta, (QUO_W - FRAC_W)'(0)};
            r      <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            if (bus.op_div && (bus.fractb == '0)) begin
              state      <= DONE;
              done_q     <= 1'b1;
              prod_q     <= '0;
              quo_q      <= '1;
              rem_q      <= '0;
              div_zero_q <= 1'b1;
            end else begin
              state <= bus.op_div ? DIV : MUL;
            end
          end
        end

        MUL: begin
          acc   <= acc_next;
          b_reg <= b_reg >> MUL_STEP;
          cnt   <= cnt + CNT_W'(MUL_STEP);
          if (mul_last) begin
            state      <= DONE;
            done_q     <= 1'b1;
            prod_q     <= acc_next;
            quo_q      <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
          end
        end

        DIV: begin
          r   <= r_next;
          dvd <= dvd_next;
          cnt <= cnt + CNT_W'(1);
          if (div_last) begin
            state      <= DONE;
            done_q     <= 1'b1;
            prod_q     <= '0;
            quo_q      <= dvd_next;
            rem_q      <= r_next[FRAC_W-1:0];
            div_zero_q <= 1'b0;
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.prod     = prod_q;
  assign bus.quo      = quo_q;
  assign bus.rem      = rem_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_fract_muldiv_seq.sv
// Self-checking bench for fract_muldiv_seq: directed corner cases plus random
// operands compared against plain integer multiply/divide.
module tb_fract_muldiv_seq;

`ifdef FMUL_RADIX4_EN
  localparam int MUL_LAT = 13;
`else
  localparam int MUL_LAT = 25;
`endif
  localparam int DIV_LAT = 51;
  localparam int MAX_LAT = 200;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [47:0] e_prod;
  logic [49:0] e_quo;
  logic [23:0] e_rem;
  logic        e_dz;

  fract_muldiv_seq_if bus ();

  fract_muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, or integer quotient/remainder of fracta*2^26 / fractb.
  task automatic compute_expected(input logic op, input logic [23:0] a, input logic [23:0] b);
    logic [63:0] dividend;
    dividend = {14'b0, a, 26'b0};
    e_prod = '0; e_quo = '0; e_rem = '0; e_dz = 1'b0;
    if (!op) begin
      e_prod = {24'b0, a} * {24'b0, b};
    end else if (b == 24'd0) begin
      e_quo = '1;
      e_dz  = 1'b1;
    end else begin
      e_quo = 50'(dividend / {40'b0, b});
      e_rem = 24'(dividend % {40'b0, b});
    end
  endtask

  // Runs one operation and compares latency and all result fields; optionally
  // pokes start (with a different op) while the core is busy.
  task automatic run_op(input string name, input logic op, input logic [23:0] a,
                        input logic [23:0] b, input bit poke);
    int lat;
    int exp_lat;
    compute_expected(op, a, b);
    exp_lat = !op ? MUL_LAT : (b == 24'd0 ? 1 : DIV_LAT);
    @(negedge clk);
    bus.op_div = op; bus.fracta = a; bus.fractb = b; bus.start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    bus.start = 1'b0;
    bus.fracta = 24'($urandom); bus.fractb = 24'($urandom); bus.op_div = ~op;
    while (!bus.done && lat < MAX_LAT) begin
      @(posedge clk); #1;
      lat++;
      bus.start = poke && (lat == 5);
    end
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (done=%b) expected %0d", name, lat, bus.done, exp_lat);
    end
    checks++;
    if (bus.prod !== e_prod || bus.quo !== e_quo || bus.rem !== e_rem || bus.div_zero !== e_dz) begin
      errors++;
      $display("FAIL %s result: got prod=%h quo=%h rem=%h dz=%b expected prod=%h quo=%h rem=%h dz=%b",
               name, bus.prod, bus.quo, bus.rem, bus.div_zero, e_prod, e_quo, e_rem, e_dz);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b expected 1", name, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.op_div = 1'b0; bus.fracta = '0; bus.fractb = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.prod, bus.quo, bus.rem, bus.div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b prod=%h quo=%h rem=%h dz=%b expected all 0",
               bus.busy, bus.done, bus.prod, bus.quo, bus.rem, bus.div_zero);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_op("mul_half_half", 1'b0, 24'h800000, 24'h800000, 1'b0);
    checks++;
    if (bus.prod !== 48'h400000000000) begin
      errors++;
      $display("FAIL mul_half_const: got %h expected 400000000000", bus.prod);
    end
    run_op("mul_max_max", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
    checks++;
    if (bus.prod !== 48'hFFFFFE000001) begin
      errors++;
      $display("FAIL mul_max_const: got %h expected fffffe000001", bus.prod);
    end
    run_op("div_c0_80", 1'b1, 24'hC00000, 24'h800000, 1'b0);
    run_op("div_80_c0", 1'b1, 24'h800000, 24'hC00000, 1'b0);
    run_op("div_max_1", 1'b1, 24'hFFFFFF, 24'h000001, 1'b0);
    run_op("mul_zero", 1'b0, 24'h000000, 24'hABCDEF, 1'b0);
    run_op("mul_denorm", 1'b0, 24'h000003, 24'h7FFFFF, 1'b0);
  endtask

  task automatic test_random_mul();
    for (int i = 0; i < 8; i++) begin
      logic [23:0] a, b;
      a = 24'($urandom);
      b = (i == 0) ? 24'd0 : 24'($urandom);
      run_op("rand_mul", 1'b0, a, b, 1'b0);
    end
  endtask

  task automatic test_random_div();
    for (int i = 0; i < 8; i++) begin
      logic [23:0] a, b;
      a = 24'($urandom);
      b = (i < 2) ? 24'($urandom_range(1, 255)) : 24'($urandom_range(1, 24'hFFFFFF));
      run_op("rand_div", 1'b1, a, b, 1'b0);
    end
  endtask

  task automatic test_div_zero();
    compute_expected(1'b1, 24'h5A5A5A, 24'd0);
    @(negedge clk);
    bus.op_div = 1'b1; bus.fracta = 24'h5A5A5A; bus.fractb = 24'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.div_zero !== 1'b1 || bus.quo !== e_quo ||
        bus.rem !== 24'd0 || bus.prod !== 48'd0) begin
      errors++;
      $display("FAIL div_zero: got done=%b dz=%b quo=%h rem=%h prod=%h expected 1 1 %h 0 0",
               bus.done, bus.div_zero, bus.quo, bus.rem, bus.prod, e_quo);
    end
    bus.op_div = 1'b0; bus.fracta = 24'h123456; bus.fractb = 24'h654321;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b1) begin
        errors++;
        $display("FAIL div_zero_start_ignored: got busy=%b done=%b dz=%b expected 0 0 1",
                 bus.busy, bus.done, bus.div_zero);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_poke_mul", 1'b0, 24'h9ABCDE, 24'h13579B, 1'b1);
    run_op("b2b_poke_div", 1'b1, 24'hF00001, 24'h80000F, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op("b2b_mix", 1'($urandom), 24'($urandom), 24'($urandom_range(1, 24'hFFFFFF)), 1'b0);
  endtask

  task automatic test_hold();
    run_op("hold_setup", 1'b1, 24'hDEADBE, 24'h00F00D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.quo !== e_quo || bus.rem !== e_rem || bus.prod !== e_prod ||
          bus.div_zero !== e_dz || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got quo=%h rem=%h done=%b expected quo=%h rem=%h done=0",
                 i, bus.quo, bus.rem, bus.done, e_quo, e_rem);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    @(negedge clk);
    bus.op_div = 1'b0; bus.fracta = 24'hFFFFFF; bus.fractb = 24'hFFFFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (lat < 11) begin
      @(posedge clk); #1;
      lat++;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.prod, bus.quo, bus.rem, bus.div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b prod=%h quo=%h expected all 0",
               bus.busy, bus.done, bus.prod, bus.quo);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < MUL_LAT; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
      end
    end
    run_op("after_reset_mul", 1'b0, 24'hC0FFEE, 24'hBADA55, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random_mul();
    test_random_div();
    test_div_zero();
    test_back_to_back();
    test_hold();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
